// File: rtl/uart_rx_frontend.sv
// uart_rx_frontend: 8N1 UART receiver front end for the CPU UART peripheral.
// It synchronises the pad and oversamples each bit at 16x baud. Each character
// is framed and checked, then held in a one-deep register with sticky status
// until the CPU acknowledges it.
//
// Ports:
//   sysclk     in   system clock, rising edge
//   reset      in   synchronous active-low reset
//   UART_RX    in   asynchronous serial line, idle high
//   rx_ack     in   CPU read pulse: clears rx_valid, frame_err, overrun
//   rx_data    out  [7:0] last received byte
//   rx_valid   out  unread byte present
//   frame_err  out  sticky: stop bit sampled low
//   overrun    out  sticky: byte completed while rx_valid already set
//
// Optional build macro: UART_RX_MAJORITY_EN. When it is defined, each bit is
// the 2-of-3 majority of the samples at sub-bits 7, 8 and 9, and the decision
// is made at sub-bit 9. Otherwise a single sample is taken at sub-bit 8.
module uart_rx_frontend #(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned BAUD     = 9600,
    parameter int unsigned OVS_DIV  = CLK_FREQ / (BAUD * 16)
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       UART_RX,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun
);

    localparam int unsigned TW = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_e;

    state_e          state_q, state_d;
    logic            rx_meta_q, rxs_q;
    logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
    logic [3:0]      sub_cnt_q, sub_cnt_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shreg_q, shreg_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            rx_valid_q, rx_valid_d;
    logic            frame_err_q, frame_err_d;
    logic            overrun_q, overrun_d;
    logic            tick_c;
    logic            mid_c;
    logic            bit_c;

    assign tick_c = (tick_cnt_q == TW'(OVS_DIV - 1));

`ifdef UART_RX_MAJORITY_EN
    // Samples from sub-bits 7 and 8; the live rxs is the sub-bit 9 sample.
    logic [1:0] maj_q, maj_d;

    assign mid_c = tick_c && (sub_cnt_q == 4'd8);
    assign bit_c = (maj_q[1] & maj_q[0]) | (maj_q[1] & rxs_q) | (maj_q[0] & rxs_q);

    always_comb begin
        maj_d = maj_q;
        if (tick_c && ((sub_cnt_q == 4'd6) || (sub_cnt_q == 4'd7))) begin
            maj_d = {maj_q[0], rxs_q};
        end
    end

    always_ff @(posedge sysclk) begin
        if (!reset) begin
            maj_q <= 2'b11;
        end else begin
            maj_q <= maj_d;
        end
    end
`else
    // The tick that moves the sub-bit counter onto 8 is the mid-bit sample.
    assign mid_c = tick_c && (sub_cnt_q == 4'd7);
    assign bit_c = rxs_q;
`endif

    // Next-state and output logic
    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_c ? '0 : tick_cnt_q + TW'(1);
        sub_cnt_d   = tick_c ? sub_cnt_q + 4'd1 : sub_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        frame_err_d = frame_err_q;
        overrun_d   = overrun_q;

        // A CPU read clears status. A commit in the same cycle re-sets rx_valid below.
        if (rx_ack) begin
            rx_valid_d  = 1'b0;
            frame_err_d = 1'b0;
            overrun_d   = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                // Align tick phase to the start edge.
                if (!rxs_q) begin
                    state_d    = ST_START;
                    tick_cnt_d = '0;
                    sub_cnt_d  = '0;
                end
            end
            ST_START: begin
                if (mid_c) begin
                    if (!bit_c) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = 3'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (mid_c) begin
                    shreg_d   = {bit_c, shreg_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (mid_c) begin
                    if (bit_c) begin
                        rx_data_d  = shreg_q;
                        rx_valid_d = 1'b1;
                        if (rx_valid_q && !rx_ack) begin
                            overrun_d = 1'b1;
                        end
                        state_d = ST_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                if (rxs_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counters, synchroniser and output registers
    always_ff @(posedge sysclk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            rx_meta_q   <= 1'b1;
            rxs_q       <= 1'b1;
            tick_cnt_q  <= '0;
            sub_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_meta_q   <= UART_RX;
            rxs_q       <= rx_meta_q;
            tick_cnt_q  <= tick_cnt_d;
            sub_cnt_q   <= sub_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Testbench for uart_rx_frontend, with a scaled-down baud (4 sysclk per
// oversample tick, 64 per bit). A frame-level model predicts the edge at
// which each frame commits, and the expected register contents after it.
// Every cycle the outputs are compared against that model.
module tb_uart_rx_frontend;

    localparam int unsigned D   = 4;
    localparam int unsigned BIT = 16 * D;
`ifdef UART_RX_MAJORITY_EN
    localparam int unsigned MID = 9 * D;
`else
    localparam int unsigned MID = 8 * D;
`endif
    // The start level is driven at a negedge. The next edge is the first
    // synchroniser edge. Two more edges bring it to the detect edge. The
    // stop-bit decision then follows 9 bit periods plus MID later.
    localparam int LAT = 3 + 9 * BIT + MID;

    logic       sysclk = 1'b0;
    logic       reset;
    logic       UART_RX;
    logic       rx_ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;

    uart_rx_frontend #(
        .CLK_FREQ(1_000_000),
        .BAUD    (15_625),
        .OVS_DIV (D)
    ) dut (
        .sysclk   (sysclk),
        .reset    (reset),
        .UART_RX  (UART_RX),
        .rx_ack   (rx_ack),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #5 sysclk = ~sysclk;

    // Driver-owned frame schedule
    int         drv_start = -1;
    int         drv_edge  = -1;
    logic       drv_good  = 1'b0;
    logic [7:0] drv_byte  = 8'h00;

    // Model-owned state
    int         cyc      = 0;
    int         last_rst = 0;
    logic [7:0] exp_data = 8'h00;
    logic       exp_valid = 1'b0;
    logic       exp_fe   = 1'b0;
    logic       exp_ov   = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Frame-level reference model, evaluated at each clock edge
    always @(posedge sysclk) begin
        cyc = cyc + 1;
        if (!reset) begin
            exp_data  = 8'h00;
            exp_valid = 1'b0;
            exp_fe    = 1'b0;
            exp_ov    = 1'b0;
            last_rst  = cyc;
        end else if (cyc == drv_edge && drv_start > last_rst) begin
            if (drv_good) begin
                exp_ov    = rx_ack ? 1'b0 : (exp_ov | exp_valid);
                exp_fe    = rx_ack ? 1'b0 : exp_fe;
                exp_data  = drv_byte;
                exp_valid = 1'b1;
            end else begin
                exp_fe = 1'b1;
                if (rx_ack) begin
                    exp_valid = 1'b0;
                    exp_ov    = 1'b0;
                end
            end
        end else if (rx_ack) begin
            exp_valid = 1'b0;
            exp_fe    = 1'b0;
            exp_ov    = 1'b0;
        end
    end

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge sysclk);
            UART_RX = 1'b1;
            rx_ack  = 1'b0;
        end
    endtask

    task automatic pulse_ack();
        @(negedge sysclk);
        UART_RX = 1'b1;
        rx_ack  = 1'b1;
        @(negedge sysclk);
        rx_ack  = 1'b0;
    endtask

    // Full frame. A low stop bit is followed by two more bit times low.
    // With ack_commit set, rx_ack is placed on the predicted commit edge.
    task automatic send_frame(input logic [7:0] b, input logic stop, input bit ack_commit);
        logic [9:0] bits;
        int         ce;
        bits = {stop, b, 1'b0};
        @(negedge sysclk);
        ce        = cyc + LAT;
        drv_start = cyc;
        drv_edge  = ce;
        drv_good  = stop;
        drv_byte  = b;
        for (int t = 0; t < 10 * BIT; t++) begin
            if (t != 0) @(negedge sysclk);
            UART_RX = bits[t / BIT];
            rx_ack  = ack_commit && stop && (cyc == ce - 1);
        end
        if (!stop) begin
            repeat (2 * BIT) begin
                @(negedge sysclk);
                UART_RX = 1'b0;
                rx_ack  = 1'b0;
            end
        end
        @(negedge sysclk);
        UART_RX = 1'b1;
        rx_ack  = 1'b0;
    endtask

    task automatic glitch(input int len);
        repeat (len) begin
            @(negedge sysclk);
            UART_RX = 1'b0;
            rx_ack  = 1'b0;
        end
        idle(BIT);
    endtask

    // Start a frame and pull reset halfway through data bit 4.
    task automatic reset_mid(input logic [7:0] b);
        logic [9:0] bits;
        bits = {1'b1, b, 1'b0};
        @(negedge sysclk);
        drv_start = cyc;
        drv_edge  = cyc + LAT;
        drv_good  = 1'b1;
        drv_byte  = b;
        UART_RX   = 1'b0;
        for (int t = 1; t < 5 * BIT + BIT / 2; t++) begin
            @(negedge sysclk);
            UART_RX = bits[t / BIT];
        end
        @(negedge sysclk);
        reset   = 1'b0;
        UART_RX = 1'b1;
        @(negedge sysclk);
        reset = 1'b1;
    endtask

    initial begin
        int r;
        reset   = 1'b0;
        UART_RX = 1'b1;
        rx_ack  = 1'b0;

        // Per-cycle compare against the model
        fork
            forever begin
                @(negedge sysclk);
                if (chk_en) begin
                    n_tests++;
                    if ({rx_data, rx_valid, frame_err, overrun} !==
                        {exp_data, exp_valid, exp_fe, exp_ov}) begin
                        n_fail++;
                        $display("FAIL cycle %0d: dut data=%h v=%b fe=%b ov=%b, model data=%h v=%b fe=%b ov=%b",
                                 cyc, rx_data, rx_valid, frame_err, overrun,
                                 exp_data, exp_valid, exp_fe, exp_ov);
                    end
                end
            end
        join_none

        @(negedge sysclk);
        reset  = 1'b1;
        chk_en = 1'b1;
        check("reset_data", rx_data, 8'h00);
        check("reset_valid", 8'(rx_valid), 8'h00);
        check("reset_fe", 8'(frame_err), 8'h00);
        check("reset_ov", 8'(overrun), 8'h00);
        idle(20);

        // Basic byte, held until acknowledged
        send_frame(8'h54, 1'b1, 1'b0);
        check("t1_data", rx_data, 8'h54);
        check("t1_valid", 8'(rx_valid), 8'h01);
        idle(BIT);
        check("t1_hold", rx_data, 8'h54);
        check("t1_hold_valid", 8'(rx_valid), 8'h01);

        // Ack then a second byte
        pulse_ack();
        check("t2_ack_valid", 8'(rx_valid), 8'h00);
        idle(10);
        send_frame(8'h0C, 1'b1, 1'b0);
        check("t2_data", rx_data, 8'h0C);
        check("t2_valid", 8'(rx_valid), 8'h01);
        check("t2_ov", 8'(overrun), 8'h00);
        check("t2_fe", 8'(frame_err), 8'h00);
        pulse_ack();
        idle(10);

        // Short low pulse is rejected, then a clean frame
        glitch(18);
        check("t3_valid", 8'(rx_valid), 8'h00);
        send_frame(8'hA5, 1'b1, 1'b0);
        check("t3_data", rx_data, 8'hA5);
        check("t3_valid2", 8'(rx_valid), 8'h01);
        pulse_ack();
        idle(10);

        // Framing error, then a good byte with the error still sticky
        send_frame(8'h3C, 1'b0, 1'b0);
        idle(8);
        check("t4_fe", 8'(frame_err), 8'h01);
        check("t4_valid", 8'(rx_valid), 8'h00);
        send_frame(8'h11, 1'b1, 1'b0);
        check("t4_data", rx_data, 8'h11);
        check("t4_valid2", 8'(rx_valid), 8'h01);
        check("t4_fe_sticky", 8'(frame_err), 8'h01);
        pulse_ack();
        check("t4_fe_clr", 8'(frame_err), 8'h00);
        idle(10);

        // Overrun, then ack landing on the commit edge
        send_frame(8'h54, 1'b1, 1'b0);
        send_frame(8'h0C, 1'b1, 1'b0);
        check("t5_data", rx_data, 8'h0C);
        check("t5_ov", 8'(overrun), 8'h01);
        pulse_ack();
        check("t5_valid_clr", 8'(rx_valid), 8'h00);
        check("t5_ov_clr", 8'(overrun), 8'h00);
        idle(10);
        send_frame(8'h54, 1'b1, 1'b0);
        send_frame(8'h0C, 1'b1, 1'b1);
        check("t5_ack_commit_valid", 8'(rx_valid), 8'h01);
        check("t5_ack_commit_ov", 8'(overrun), 8'h00);
        check("t5_ack_commit_data", rx_data, 8'h0C);
        idle(10);

        // Reset mid-frame with a byte pending, then a full 0xFF frame
        reset_mid(8'h96);
        check("t6_rst_data", rx_data, 8'h00);
        check("t6_rst_valid", 8'(rx_valid), 8'h00);
        check("t6_rst_fe", 8'(frame_err), 8'h00);
        check("t6_rst_ov", 8'(overrun), 8'h00);
        idle(BIT);
        send_frame(8'hFF, 1'b1, 1'b0);
        check("t6_data", rx_data, 8'hFF);
        check("t6_valid", 8'(rx_valid), 8'h01);
        idle(10);

        // Randomised traffic against the model
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                glitch($urandom_range(1, 6 * D));
            end else if (r == 1) begin
                send_frame(8'($urandom), 1'b0, 1'b0);
            end else if (r <= 3) begin
                pulse_ack();
            end else begin
                send_frame(8'($urandom), 1'b1, ($urandom_range(0, 3) == 0));
            end
            idle($urandom_range(4, 40));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_frontend.md
Name: uart_rx_frontend

Overview:
- Asynchronous 8N1 UART receiver feeding the CPU's memory-mapped UART peripheral registers (RX data and status words).
- Synchronises the UART_RX pad, oversamples at 16x baud, frames and validates each character, and holds it in a one-deep holding register with sticky status until the CPU acknowledges it.
- Sits directly between the board's UART_RX pin and the CPU peripheral bus decode logic.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD, 9600, line rate in bit/s.
- OVS_DIV, CLK_FREQ/(BAUD*16), sysclk cycles per oversample tick (default 651, giving a bit period of 10416 cycles ≈ 104.16 us).

Ports:
- sysclk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-low reset.
- UART_RX  input  1  asynchronous serial line; idle state is high.
- rx_ack  input  1  single-cycle pulse from the CPU read of the RX data register; clears rx_valid, frame_err and overrun.
- rx_data  output  8  last received byte, LSB-first assembled.
- rx_valid  output  1  high when rx_data holds an unread byte.
- frame_err  output  1  sticky flag: a stop bit was sampled low.
- overrun  output  1  sticky flag: a byte completed while rx_valid was already set.

Behaviour:
- Reset (reset==0 at a sysclk edge): rx_data=8'h00, rx_valid=0, frame_err=0, overrun=0, FSM=IDLE, tick and bit counters=0, synchroniser flops=1. Reset mid-frame abandons the frame; no partial byte is ever visible.
- Input path: 2-flop synchroniser on UART_RX; all decisions use the synchronised value rxs (2-cycle latency).
- Tick generator: counts 0..OVS_DIV-1 and emits a one-cycle tick at the wrap. It is forced to 0 when IDLE detects a start edge, so that ticks are phase-aligned to the edge.
- Sub-bit counter: 0..15 per bit, advancing on each tick; the mid-bit sample is taken at sub-bit 8.
- FSM states:
  - IDLE: on rxs==0 -> START, with counters cleared.
  - START: at mid-sample, if the sample is 0 -> DATA with bit_cnt=0; if 1 -> IDLE (glitch rejected, no flag set).
  - DATA: at each mid-sample, shift the sample into the shift register MSB, so that after 8 bits it holds LSB-first data. After bit 7 -> STOP.
  - STOP: at mid-sample:
    - Sample 1: rx_data <= shift register; rx_valid <= 1; overrun <= 1 if rx_valid was already 1 and rx_ack is not asserted that cycle; -> IDLE.
    - Sample 0: frame_err <= 1; rx_data and rx_valid unchanged; -> BREAK.
  - BREAK: wait for rxs==1, then -> IDLE. A held-low line never produces bytes.
- Return to IDLE occurs at mid-stop, leaving half a bit of margin to catch the next start edge.
- Latency: rx_valid rises one sysclk after the stop-bit mid-sample, about 9.5 bit periods + 3 cycles after the start edge on the pad.
- Handshake: rx_ack clears rx_valid, frame_err and overrun on the next edge. If rx_ack coincides with a new byte commit:
  - new data is loaded;
  - rx_valid stays 1;
  - overrun and frame_err end up 0.
- An rx_ack with rx_valid==0 has no effect other than clearing the flags.
- Overrun policy: the newest byte overwrites rx_data; the old byte is lost.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- When defined: each bit value (start, data, stop) is the 2-of-3 majority of samples taken at sub-bits 7, 8 and 9, and the decision is made at sub-bit 9.
- When undefined: a single sample is taken at sub-bit 8.
- All other timing and behaviour is identical.

Test Plan:
1. Reset low 10 ns then high; drive frame start,0,0,1,0,1,0,1,0,stop at 104167 ns/bit -> rx_data=8'h54 (84), rx_valid=1 about 990 us after the start edge; the value holds until rx_ack.
2. Byte 8'h54, pulse rx_ack, then frame 0,0,1,1,0,0,0,0 -> rx_data=8'h0C (12), rx_valid=1, overrun=0, frame_err=0.
3. Drive UART_RX low for 3000 cycles (under half a bit), then high -> rx_valid stays 0, FSM returns to IDLE, and a following 8'hA5 frame is received correctly.
4. Send 8'h3C with stop bit 0, line held low for 2 bit times then high -> frame_err=1, rx_valid=0; a subsequent 8'h11 frame gives rx_valid=1 with frame_err still 1 until rx_ack.
5. Send 8'h54 then 8'h0C with no rx_ack -> rx_data=8'h0C, overrun=1; one rx_ack pulse -> rx_valid=0, overrun=0. Repeat with rx_ack timed on the commit cycle -> rx_valid=1, overrun=0.
6. Assert reset during data bit 4 of a frame -> all outputs 0 in the next cycle; after release and line idle, a full 8'hFF frame is received correctly.
